// File: rtl/full_tree_adder_pkg.sv
// Shared helpers for the Kogge-Stone adder.
//   num_stages(n): number of prefix-tree levels, ceil(log2(n)), for n >= 2.
package full_tree_adder_pkg;

    function automatic int num_stages(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << s) < n) s = s + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/full_tree_adder_pg_black_cell.sv
// Prefix-tree black cell: merges a high (gh, ph) group with the adjacent
// low (gl, pl) group into one combined generate/propagate pair.
//   gh_i, ph_i : generate/propagate of the upper group
//   gl_i, pl_i : generate/propagate of the lower group
//   g_o, p_o   : combined generate/propagate
module pg_black_cell (
    input  logic gh_i,
    input  logic ph_i,
    input  logic gl_i,
    input  logic pl_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gh_i | (ph_i & gl_i);
    assign p_o = ph_i & pl_i;

endmodule

// File: rtl/full_tree_adder.sv
// N_BIT-wide adder built as a valence-2 Kogge-Stone parallel-prefix tree.
// Purely combinational; clk/rst_n are present only for interface uniformity.
//   clk, rst_n          : unused by the datapath
//   operand_1/operand_2 : addends A and B
//   carry_in            : carry into bit 0
//   sum                 : (A + B + carry_in) mod 2^N_BIT
//   carry_out           : carry out of the MSB (unsigned overflow)
//   overflow            : signed two's-complement overflow
module full_tree_adder
    import full_tree_adder_pkg::*;
#(
    parameter int N_BIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BIT-1:0] operand_1,
    input  logic [N_BIT-1:0] operand_2,
    input  logic             carry_in,
    output logic [N_BIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = num_stages(N_BIT);

    // Row 0 holds the per-bit pre-processing; row k+1 is the output of level k.
    logic [STAGES:0][N_BIT-1:0] g_t;
    logic [STAGES:0][N_BIT-1:0] p_t;

    logic [N_BIT-1:0] g_pre;
    logic [N_BIT-1:0] p_pre;
    logic [N_BIT-1:0] carry;

    assign p_pre = operand_1 ^ operand_2;

    // Bit 0 folds carry_in into its generate, so the tree output at bit i
    // is directly the carry into bit i+1.
    assign g_pre[0] = (operand_1[0] & operand_2[0]) | (p_pre[0] & carry_in);
    assign g_pre[N_BIT-1:1] = operand_1[N_BIT-1:1] & operand_2[N_BIT-1:1];

    assign g_t[0] = g_pre;
    assign p_t[0] = p_pre;

    for (genvar lvl = 0; lvl < STAGES; lvl++) begin : g_lvl
        localparam int D = 1 << lvl;
        for (genvar i = 0; i < N_BIT; i++) begin : g_bit
            if (i >= D) begin : g_black
                pg_black_cell u_cell (
                    .gh_i (g_t[lvl][i]),
                    .ph_i (p_t[lvl][i]),
                    .gl_i (g_t[lvl][i-D]),
                    .pl_i (p_t[lvl][i-D]),
                    .g_o  (g_t[lvl+1][i]),
                    .p_o  (p_t[lvl+1][i])
                );
            end else begin : g_buf
                // Bits below the span already hold their complete prefix.
                assign g_t[lvl+1][i] = g_t[lvl][i];
                assign p_t[lvl+1][i] = p_t[lvl][i];
            end
        end
    end

    assign carry     = {g_t[STAGES][N_BIT-2:0], carry_in};
    assign sum       = p_pre ^ carry;
    assign carry_out = g_t[STAGES][N_BIT-1];
    assign overflow  = (operand_1[N_BIT-1] == operand_2[N_BIT-1]) &&
                       (sum[N_BIT-1] != operand_1[N_BIT-1]);

    // Sink for ports and final-row propagates that have no consumer.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, p_t[STAGES]};

endmodule

// File: tb/tb_full_tree_adder.sv
module tb_full_tree_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] a, b;
    logic        cin;

    logic [63:0] s64;  logic co64, ov64;
    logic [12:0] s13;  logic co13, ov13;
    logic [1:0]  s2;   logic co2,  ov2;

    full_tree_adder #(.N_BIT(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .operand_1(a), .operand_2(b), .carry_in(cin),
        .sum(s64), .carry_out(co64), .overflow(ov64));
    full_tree_adder #(.N_BIT(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .operand_1(a[12:0]), .operand_2(b[12:0]), .carry_in(cin),
        .sum(s13), .carry_out(co13), .overflow(ov13));
    full_tree_adder #(.N_BIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .operand_1(a[1:0]), .operand_2(b[1:0]), .carry_in(cin),
        .sum(s2), .carry_out(co2), .overflow(ov2));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    // Golden model: wide arithmetic on the operands truncated to n bits.
    function automatic void ref_add(input int n, input logic [63:0] ra, input logic [63:0] rb,
                                    input logic rc, output logic [63:0] rs,
                                    output logic rco, output logic rov);
        logic [64:0] mask, full;
        mask = (65'd1 << n) - 65'd1;
        full = ({1'b0, ra} & mask) + ({1'b0, rb} & mask) + {64'd0, rc};
        rs   = full[63:0] & mask[63:0];
        rco  = full[n];
        rov  = (ra[n-1] == rb[n-1]) && (rs[n-1] != ra[n-1]);
    endfunction

    task automatic cmp(input string name, input int n, input logic [63:0] act_s,
                       input logic act_co, input logic act_ov, input logic [63:0] es,
                       input logic eco, input logic eov);
        n_tests++;
        if (act_s !== es || act_co !== eco || act_ov !== eov) begin
            n_fail++;
            $display("FAIL %s n=%0d a=%h b=%h cin=%b got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                     name, n, a, b, cin, act_s, act_co, act_ov, es, eco, eov);
        end
    endtask

    task automatic check_model(input string name);
        logic [63:0] es; logic eco, eov;
        ref_add(64, a, b, cin, es, eco, eov);
        cmp(name, 64, s64, co64, ov64, es, eco, eov);
        ref_add(13, a, b, cin, es, eco, eov);
        cmp(name, 13, {51'd0, s13}, co13, ov13, es, eco, eov);
        ref_add(2, a, b, cin, es, eco, eov);
        cmp(name, 2, {62'd0, s2}, co2, ov2, es, eco, eov);
    endtask

    // Change inputs just after the posedge, sample at the following negedge.
    task automatic apply(input logic [63:0] na, input logic [63:0] nb, input logic nc);
        @(posedge clk);
        #1;
        a = na; b = nb; cin = nc;
        @(negedge clk);
    endtask

    vec_t tbl[6];

    initial begin
        rst_n = 1'b1;
        a = '0; b = '0; cin = 1'b0;

        tbl[0] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        tbl[4] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        tbl[5] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1, 1'b0};

        // Directed 64-bit table; the narrow instances are checked by the model.
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].cin);
            cmp($sformatf("directed%0d", i), 64, s64, co64, ov64, tbl[i].sum, tbl[i].co, tbl[i].ov);
            check_model($sformatf("directed%0d_model", i));
        end

        // Narrow-width boundaries: 01+01 overflows 2 bits signed; 3+0+1 wraps.
        apply(64'h1, 64'h1, 1'b0);
        cmp("n2_pos_ovf", 2, {62'd0, s2}, co2, ov2, 64'h2, 1'b0, 1'b1);
        apply(64'h3, 64'h0, 1'b1);
        cmp("n2_wrap", 2, {62'd0, s2}, co2, ov2, 64'h0, 1'b1, 1'b0);
        apply(64'h0FFF, 64'h0, 1'b1);
        cmp("n13_wrap", 13, {51'd0, s13}, co13, ov13, 64'h1000, 1'b0, 1'b1);

        // Reset has no effect: outputs keep tracking inputs while held in reset.
        rst_n = 1'b0;
        apply(64'h1234, 64'h0001, 1'b1);
        cmp("in_reset", 64, s64, co64, ov64, 64'h1236, 1'b0, 1'b0);
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cmp("in_reset_chg", 64, s64, co64, ov64, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_model("after_reset");

        // Random vectors with random reset toggling; some biased toward long carries.
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = ~ra;
                1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            rst_n = 1'($urandom_range(0, 1));
            apply(ra, rb, 1'($urandom_range(0, 1)));
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
